// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter: round-robin sharing of one SPI shifter between on-chip requesters
module spi_req_arbiter #(
    parameter int N_REQ          = 4,
    parameter int DATA_W         = 24,
    parameter int GAP_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      enable,
    input  logic                      cpu_csn_sync,
    input  logic                      tx_active,
    input  logic [N_REQ-1:0]          hold_mask,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ack,
    output logic                      spi_start,
    output logic [DATA_W-1:0]         spi_word,
    input  logic                      spi_done,
    output logic                      busy,
    output logic [2:0]                grant_idx,
    output logic                      err_timeout,
    output logic [15:0]               txn_count
);
    localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;
    state_t state, nxt;
    logic [2:0] ptr, win;
    logic [N_REQ-1:0] elig;
    logic [DATA_W-1:0] word;
    logic [TW-1:0] to_cnt;
    logic [15:0] gap_cnt;
    logic grant, tmo_hit, gap_done;
    assign busy = state != IDLE;
    // pick the first eligible requester after the pointer; the pointer itself is searched last
    always_comb begin
        elig = req_valid & ~(hold_mask & {N_REQ{tx_active}});
        win = ptr;
        for (int k = N_REQ; k >= 1; k--)
            for (int i = 0; i < N_REQ; i++)
                if (elig[i] && (int'(ptr) + k) % N_REQ == i) win = 3'(i);
        word = '0;
        for (int i = 0; i < N_REQ; i++)
            if (win == 3'(i)) word = req_data[i*DATA_W +: DATA_W];
    end
    // next-state logic; a zero or one cycle gap both leave GAP after its first cycle
    always_comb begin
        tmo_hit = to_cnt == TW'(TIMEOUT_CYCLES - 1);
        gap_done = GAP_CYCLES <= 1 || gap_cnt == 16'(GAP_CYCLES - 1);
        grant = state == IDLE && enable && cpu_csn_sync && |elig;
        nxt = state == IDLE  ? (grant ? ISSUE : IDLE) :
              state == ISSUE ? WAIT :
              state == WAIT  ? (spi_done || tmo_hit ? GAP : WAIT) :
                               (gap_done ? IDLE : GAP);
    end
    // state, registered handshake outputs, counters and status
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            ptr         <= 3'(N_REQ - 1);
            req_ack     <= '0;
            spi_start   <= 1'b0;
            spi_word    <= '0;
            grant_idx   <= '0;
            err_timeout <= 1'b0;
            txn_count   <= '0;
            to_cnt      <= '0;
            gap_cnt     <= '0;
        end else begin
            state     <= nxt;
            req_ack   <= grant ? N_REQ'(1) << win : '0;
            spi_start <= state == ISSUE;
            to_cnt    <= state == WAIT ? to_cnt + 1'b1 : '0;
            gap_cnt   <= state == GAP ? gap_cnt + 1'b1 : '0;
            if (grant) begin
                spi_word  <= word;
                grant_idx <= win;
                ptr       <= win;
            end
            if (state == WAIT && spi_done) txn_count <= txn_count + 1'b1;
            if (state == WAIT && !spi_done && tmo_hit) err_timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb_spi_req_arbiter: directed self-checking bench for spi_req_arbiter
module tb_spi_req_arbiter;
    localparam int N = 4, DW = 24, GAP = 8, TMO = 64;
    logic clk = 0, rstn = 0, enable = 1, cpu_csn_sync = 1, tx_active = 0, spi_done = 0;
    logic [N-1:0] hold_mask = '0, req_valid = '0, req_ack;
    logic [N*DW-1:0] req_data = '0;
    logic spi_start, busy, err_timeout;
    logic [DW-1:0] spi_word;
    logic [2:0] grant_idx;
    logic [15:0] txn_count;
    int n_cmp = 0, n_bad = 0, n, seen;

    spi_req_arbiter #(.N_REQ(N), .DATA_W(DW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .cpu_csn_sync(cpu_csn_sync),
        .tx_active(tx_active), .hold_mask(hold_mask), .req_valid(req_valid),
        .req_data(req_data), .req_ack(req_ack), .spi_start(spi_start),
        .spi_word(spi_word), .spi_done(spi_done), .busy(busy), .grant_idx(grant_idx),
        .err_timeout(err_timeout), .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ack"}, req_ack, 0);
        chk({tag, "_start"}, spi_start, 0);
        chk({tag, "_word"}, spi_word, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_gidx"}, grant_idx, 0);
        chk({tag, "_err"}, err_timeout, 0);
        chk({tag, "_txn"}, txn_count, 0);
    endtask

    task automatic do_reset();
        rstn = 0;
        tick();
        tick();
        rstn = 1;
    endtask

    task automatic wait_ack(output int cnt);
        cnt = -1;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (req_ack != 0) begin
                cnt = c;
                break;
            end
        end
    endtask

    task automatic count_activity(input int cycles, output int hits);
        hits = 0;
        repeat (cycles) begin
            tick();
            if (req_ack != 0 || spi_start) hits++;
        end
    endtask

    task automatic finish(input int idx, input logic [DW-1:0] w);
        req_valid[idx] = 1'b0;
        tick();
        chk("start", spi_start, 1);
        chk("word", spi_word, w);
        chk("ack_clr", req_ack, 0);
        spi_done = 1;
        tick();
        spi_done = 0;
        chk("start_once", spi_start, 0);
        repeat (GAP) tick();
    endtask

    task automatic do_txn(input int idx, input logic [DW-1:0] w);
        tick();
        chk("ack", req_ack, 1 << idx);
        chk("gidx", grant_idx, idx);
        finish(idx, w);
    endtask

    initial begin
        // 1: reset values, single transaction, gap before the next grant
        tick();
        tick();
        chk_reset("rst");
        rstn = 1;
        req_data[0*DW +: DW] = 24'hAAAAAA;
        req_valid = 4'b0001;
        tick();
        chk("t1_ack", req_ack, 4'b0001);
        chk("t1_busy", busy, 1);
        req_valid = 4'b0000;
        tick();
        chk("t1_start", spi_start, 1);
        chk("t1_word", spi_word, 24'hAAAAAA);
        repeat (29) tick();
        chk("t1_word_hold", spi_word, 24'hAAAAAA);
        spi_done = 1;
        tick();
        spi_done = 0;
        chk("t1_txn", txn_count, 1);
        req_data[0*DW +: DW] = 24'hBBBBBB;
        req_valid = 4'b0001;
        wait_ack(n);
        chk("t1_gap_to_ack", n, 9);
        finish(0, 24'hBBBBBB);
        chk("t1_txn2", txn_count, 2);

        // 2: round-robin order, then pointer wrap
        do_reset();
        req_data = {24'hFEDCBA, 24'hABCDEF, 24'h654321, 24'h123456};
        req_valid = 4'b1111;
        do_txn(0, 24'h123456);
        do_txn(1, 24'h654321);
        do_txn(2, 24'hABCDEF);
        do_txn(3, 24'hFEDCBA);
        req_valid = 4'b0101;
        do_txn(0, 24'h123456);
        do_txn(2, 24'hABCDEF);
        chk("t2_txn", txn_count, 6);

        // 3: CPU owns the bus
        cpu_csn_sync = 0;
        req_valid = 4'b0010;
        count_activity(100, seen);
        chk("t3_csn_block", seen, 0);
        cpu_csn_sync = 1;
        do_txn(1, 24'h654321);
        chk("t3_txn", txn_count, 7);

        // 4: hold mask while Tx active
        tx_active = 1;
        hold_mask = 4'b0001;
        req_valid = 4'b0011;
        do_txn(1, 24'h654321);
        count_activity(10, seen);
        chk("t4_held", seen, 0);
        tx_active = 0;
        do_txn(0, 24'h123456);
        chk("t4_txn", txn_count, 9);

        // 5: timeout, stray done ignored, recovery
        req_valid = 4'b0001;
        tick();
        chk("t5_ack", req_ack, 4'b0001);
        req_valid = 4'b0000;
        tick();
        chk("t5_start", spi_start, 1);
        repeat (TMO - 1) tick();
        chk("t5_err_early", err_timeout, 0);
        tick();
        chk("t5_err", err_timeout, 1);
        chk("t5_txn", txn_count, 9);
        chk("t5_busy_gap", busy, 1);
        spi_done = 1;
        tick();
        spi_done = 0;
        chk("t5_done_in_gap", txn_count, 9);
        req_valid = 4'b0100;
        wait_ack(n);
        chk("t5_recover", n, 8);
        chk("t5_gidx", grant_idx, 2);
        finish(2, 24'hABCDEF);
        chk("t5_txn2", txn_count, 10);
        chk("t5_err_sticky", err_timeout, 1);

        // 6: enable drop mid-transaction, then reset during WAIT
        req_valid = 4'b1001;
        tick();
        chk("t6_ack", req_ack, 4'b1000);
        req_valid = 4'b0001;
        tick();
        chk("t6_start", spi_start, 1);
        enable = 0;
        repeat (5) tick();
        spi_done = 1;
        tick();
        spi_done = 0;
        chk("t6_txn", txn_count, 11);
        count_activity(30, seen);
        chk("t6_no_grant", seen, 0);
        chk("t6_idle", busy, 0);
        enable = 1;
        tick();
        chk("t6_ack2", req_ack, 4'b0001);
        req_valid = 4'b0000;
        tick();
        repeat (3) tick();
        chk("t6_wait_busy", busy, 1);
        rstn = 0;
        req_valid = 4'b0011;
        tick();
        chk_reset("t6_rst");
        tick();
        chk("t6_rst_ack", req_ack, 0);
        rstn = 1;
        chk("t6_post_rst_ack", req_ack, 0);
        tick();
        chk("t6_ptr_reset", req_ack, 4'b0001);
        req_valid = 4'b0010;
        finish(0, 24'h123456);
        chk("t6_txn_after", txn_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
